// File: rtl/seq_signed_divider.sv
// seq_signed_divider
//   Sequential signed radix-2 restoring divider with a fractional result.
//   The operands are accepted through a ready/start handshake. Only one
//   division is in flight at a time. The last result is held on the output
//   ports until the next division completes.
//
//   The signs are stripped when a division is accepted. The magnitudes are
//   then divided one quotient bit per cycle, MSB first. The numerator is
//   |dividend| followed by FRAC_SIZE zero bits, so the low FRAC_SIZE quotient
//   bits form the fraction.
//
//   The sign fix-up phase uses two cycles:
//     1. Negate the integer and fraction fields.
//     2. Apply saturation and publish the result.
//
// Parameters
//   DATA_SIZE   operand and integer-quotient width (two's complement)
//   FRAC_SIZE   number of fractional result bits
//
// Ports
//   i_clock     rising-edge clock
//   i_reset     asynchronous active-high reset
//   i_start     request, sampled only while o_ready=1
//   i_dividend  signed dividend
//   i_divisor   signed divisor
//   o_ready     idle, can accept i_start
//   o_valid     one-cycle pulse when the result ports update
//   o_quotient  signed integer quotient, truncated toward zero
//   o_fraction  signed fraction scaled by 2^FRAC_SIZE, same sign as quotient
//   o_overflow  quotient saturated
//   o_div_zero  divisor was zero (constant 0 without the detect feature)
//
// Optional feature
//   SEQ_DIVIDER_DIV_ZERO_DETECT_EN
//     When defined, a zero divisor bypasses the iteration phase and returns a
//     saturated result with o_div_zero set.
module seq_signed_divider #(
  parameter int DATA_SIZE = 10,
  parameter int FRAC_SIZE = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [DATA_SIZE-1:0] i_dividend,
  input  logic [DATA_SIZE-1:0] i_divisor,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [DATA_SIZE-1:0] o_quotient,
  output logic [FRAC_SIZE-1:0] o_fraction,
  output logic                 o_overflow,
  output logic                 o_div_zero
);

  localparam int TOTAL = DATA_SIZE + FRAC_SIZE;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0]     LAST_ITER = CNT_W'(TOTAL - 1);
  localparam logic [DATA_SIZE-1:0] Q_MAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
  localparam logic [DATA_SIZE-1:0] Q_MIN = {1'b1, {(DATA_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN
  } state_t;

  state_t               state_q, state_d;
  logic                 signPhase_q, signPhase_d;
  logic [TOTAL-1:0]     numer_q, numer_d;
  logic [DATA_SIZE-1:0] divisorMag_q, divisorMag_d;
  logic [DATA_SIZE-1:0] rem_q, rem_d;
  logic [TOTAL-1:0]     quot_q, quot_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 negative_q, negative_d;
  logic [DATA_SIZE-1:0] stageInt_q, stageInt_d;
  logic [FRAC_SIZE-1:0] stageFrac_q, stageFrac_d;
  logic                 stageOvf_q, stageOvf_d;
  logic [DATA_SIZE-1:0] quotient_q, quotient_d;
  logic [FRAC_SIZE-1:0] fraction_q, fraction_d;
  logic                 overflow_q, overflow_d;
  logic                 valid_q, valid_d;
`ifdef SEQ_DIVIDER_DIV_ZERO_DETECT_EN
  logic                 divZero_q, divZero_d;
  logic                 dividendNeg_q, dividendNeg_d;
  logic                 divZeroOut_q, divZeroOut_d;
`endif

  logic [DATA_SIZE-1:0] dividendMag;
  logic [DATA_SIZE-1:0] divisorMagIn;
  logic [DATA_SIZE:0]   shifted;
  logic [DATA_SIZE-1:0] trialDiff;
  logic                 trialOk;
  logic [DATA_SIZE-1:0] magInt;
  logic [FRAC_SIZE-1:0] magFrac;

  // Operand magnitudes and the restoring-divide datapath.
  // Negating -2^(DATA_SIZE-1) wraps to 2^(DATA_SIZE-1). That value is already
  // the correct unsigned magnitude, so no extra bit is needed.
  // When the trial subtract succeeds, the true difference is smaller than the
  // divisor. Its low DATA_SIZE bits are therefore exact.
  always_comb begin
    dividendMag  = i_dividend[DATA_SIZE-1] ? -i_dividend : i_dividend;
    divisorMagIn = i_divisor[DATA_SIZE-1]  ? -i_divisor  : i_divisor;
    shifted      = {rem_q, numer_q[TOTAL-1]};
    trialOk      = (shifted >= {1'b0, divisorMag_q});
    trialDiff    = shifted[DATA_SIZE-1:0] - divisorMag_q;
    magInt       = quot_q[TOTAL-1 -: DATA_SIZE];
    magFrac      = quot_q[FRAC_SIZE-1:0];
  end

  // Next-state and datapath control for IDLE -> CALC -> SIGN -> IDLE.
  // SIGN takes two cycles:
  //   - Phase 0 negates the magnitudes.
  //   - Phase 1 saturates, publishes the result and pulses valid.
  // The FSM then re-enters IDLE in the same cycle that o_valid is high, so a
  // new start can be accepted in that cycle.
  always_comb begin
    state_d      = state_q;
    signPhase_d  = signPhase_q;
    numer_d      = numer_q;
    divisorMag_d = divisorMag_q;
    rem_d        = rem_q;
    quot_d       = quot_q;
    count_d      = count_q;
    negative_d   = negative_q;
    stageInt_d   = stageInt_q;
    stageFrac_d  = stageFrac_q;
    stageOvf_d   = stageOvf_q;
    quotient_d   = quotient_q;
    fraction_d   = fraction_q;
    overflow_d   = overflow_q;
    valid_d      = 1'b0;
`ifdef SEQ_DIVIDER_DIV_ZERO_DETECT_EN
    divZero_d     = divZero_q;
    dividendNeg_d = dividendNeg_q;
    divZeroOut_d  = divZeroOut_q;
`endif

    case (state_q)
      IDLE: begin
        if (i_start) begin
          numer_d      = {dividendMag, {FRAC_SIZE{1'b0}}};
          divisorMag_d = divisorMagIn;
          rem_d        = '0;
          quot_d       = '0;
          count_d      = '0;
          negative_d   = i_dividend[DATA_SIZE-1] ^ i_divisor[DATA_SIZE-1];
          signPhase_d  = 1'b0;
          state_d      = CALC;
`ifdef SEQ_DIVIDER_DIV_ZERO_DETECT_EN
          divZero_d     = (i_divisor == '0);
          dividendNeg_d = i_dividend[DATA_SIZE-1];
          if (i_divisor == '0) begin
            state_d = SIGN;
          end
`endif
        end
      end

      CALC: begin
        numer_d = numer_q << 1;
        if (trialOk) begin
          rem_d  = trialDiff;
          quot_d = {quot_q[TOTAL-2:0], 1'b1};
        end else begin
          rem_d  = shifted[DATA_SIZE-1:0];
          quot_d = {quot_q[TOTAL-2:0], 1'b0};
        end
        count_d = count_q + 1'b1;
        if (count_q == LAST_ITER) begin
          state_d = SIGN;
        end
      end

      SIGN: begin
        if (!signPhase_q) begin
          stageInt_d  = negative_q ? -magInt  : magInt;
          stageFrac_d = negative_q ? -magFrac : magFrac;
          stageOvf_d  = !negative_q && magInt[DATA_SIZE-1];
          signPhase_d = 1'b1;
        end else begin
          quotient_d = stageInt_q;
          fraction_d = stageFrac_q;
          overflow_d = stageOvf_q;
          if (stageOvf_q) begin
            quotient_d = Q_MAX;
            fraction_d = '0;
          end
`ifdef SEQ_DIVIDER_DIV_ZERO_DETECT_EN
          divZeroOut_d = divZero_q;
          if (divZero_q) begin
            quotient_d = dividendNeg_q ? Q_MIN : Q_MAX;
            fraction_d = '0;
            overflow_d = 1'b1;
          end
`endif
          valid_d     = 1'b1;
          signPhase_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers.
  // Reset discards any division that is in flight and clears the published
  // result.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= IDLE;
      signPhase_q  <= 1'b0;
      numer_q      <= '0;
      divisorMag_q <= '0;
      rem_q        <= '0;
      quot_q       <= '0;
      count_q      <= '0;
      negative_q   <= 1'b0;
      stageInt_q   <= '0;
      stageFrac_q  <= '0;
      stageOvf_q   <= 1'b0;
      quotient_q   <= '0;
      fraction_q   <= '0;
      overflow_q   <= 1'b0;
      valid_q      <= 1'b0;
`ifdef SEQ_DIVIDER_DIV_ZERO_DETECT_EN
      divZero_q     <= 1'b0;
      dividendNeg_q <= 1'b0;
      divZeroOut_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      signPhase_q  <= signPhase_d;
      numer_q      <= numer_d;
      divisorMag_q <= divisorMag_d;
      rem_q        <= rem_d;
      quot_q       <= quot_d;
      count_q      <= count_d;
      negative_q   <= negative_d;
      stageInt_q   <= stageInt_d;
      stageFrac_q  <= stageFrac_d;
      stageOvf_q   <= stageOvf_d;
      quotient_q   <= quotient_d;
      fraction_q   <= fraction_d;
      overflow_q   <= overflow_d;
      valid_q      <= valid_d;
`ifdef SEQ_DIVIDER_DIV_ZERO_DETECT_EN
      divZero_q     <= divZero_d;
      dividendNeg_q <= dividendNeg_d;
      divZeroOut_q  <= divZeroOut_d;
`endif
    end
  end

  assign o_ready    = (state_q == IDLE);
  assign o_valid    = valid_q;
  assign o_quotient = quotient_q;
  assign o_fraction = fraction_q;
  assign o_overflow = overflow_q;
`ifdef SEQ_DIVIDER_DIV_ZERO_DETECT_EN
  assign o_div_zero = divZeroOut_q;
`else
  assign o_div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_signed_divider.sv
// tb_seq_signed_divider
//   Self-checking bench for seq_signed_divider at DATA_SIZE=10, FRAC_SIZE=8.
//
//   Expected results come from plain integer division of the operand
//   magnitudes scaled by 2^FRAC_SIZE. The sign, saturation and divide-by-zero
//   rules are then applied on top.
//
//   The directed cases run back to back: each start is issued in the o_valid
//   cycle of the previous division.
module tb_seq_signed_divider;

  localparam int DATA_SIZE = 10;
  localparam int FRAC_SIZE = 8;
  localparam int TOTAL     = DATA_SIZE + FRAC_SIZE;
  localparam int BUDGET    = 60;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 start;
  logic [DATA_SIZE-1:0] dividend;
  logic [DATA_SIZE-1:0] divisor;
  logic                 ready;
  logic                 valid;
  logic [DATA_SIZE-1:0] quotient;
  logic [FRAC_SIZE-1:0] fraction;
  logic                 overflow;
  logic                 divZero;

  int checks = 0;
  int errors = 0;

  seq_signed_divider #(
    .DATA_SIZE(DATA_SIZE),
    .FRAC_SIZE(FRAC_SIZE)
  ) dut (
    .i_clock   (clock),
    .i_reset   (reset),
    .i_start   (start),
    .i_dividend(dividend),
    .i_divisor (divisor),
    .o_ready   (ready),
    .o_valid   (valid),
    .o_quotient(quotient),
    .o_fraction(fraction),
    .o_overflow(overflow),
    .o_div_zero(divZero)
  );

  always #5 clock = ~clock;

  // Compares one observed value against its expected value and records the
  // outcome in the check and error counters.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference model. It computes the magnitude quotient with ordinary integer
  // division, then applies the sign, saturation and divide-by-zero rules.
  task automatic refModel(input int a, input int b,
                          output logic [DATA_SIZE-1:0] q,
                          output logic [FRAC_SIZE-1:0] f,
                          output logic ovf, output logic dz, output int lat);
    longint na, nb, mag, intPart, fracPart;
    logic   neg;
    neg = (a < 0) != (b < 0);
    na  = (a < 0) ? -longint'(a) : longint'(a);
    nb  = (b < 0) ? -longint'(b) : longint'(b);
    lat = TOTAL + 2;
    dz  = 1'b0;
    if (nb == 0) mag = (longint'(1) << TOTAL) - 1;
    else         mag = (na << FRAC_SIZE) / nb;
    intPart  = mag >> FRAC_SIZE;
    fracPart = mag % (longint'(1) << FRAC_SIZE);
    if (!neg && intPart >= (longint'(1) << (DATA_SIZE - 1))) begin
      q   = DATA_SIZE'((longint'(1) << (DATA_SIZE - 1)) - 1);
      f   = '0;
      ovf = 1'b1;
    end else begin
      q   = neg ? DATA_SIZE'(-intPart)  : DATA_SIZE'(intPart);
      f   = neg ? FRAC_SIZE'(-fracPart) : FRAC_SIZE'(fracPart);
      ovf = 1'b0;
    end
`ifdef SEQ_DIVIDER_DIV_ZERO_DETECT_EN
    if (b == 0) begin
      dz  = 1'b1;
      ovf = 1'b1;
      f   = '0;
      q   = (a < 0) ? DATA_SIZE'(-(longint'(1) << (DATA_SIZE - 1)))
                    : DATA_SIZE'((longint'(1) << (DATA_SIZE - 1)) - 1);
      lat = 2;
    end
`endif
  endtask

  // Presents the operands with start high for one edge. After acceptance the
  // operands are scrambled so that any late sampling would show up.
  task automatic applyStimulus(input int a, input int b);
    dividend = DATA_SIZE'(a);
    divisor  = DATA_SIZE'(b);
    start    = 1'b1;
    @(posedge clock);
    #1;
    start    = 1'b0;
    dividend = DATA_SIZE'($urandom());
    divisor  = DATA_SIZE'($urandom());
  endtask

  // Runs one division and checks the latency, result and flags against the
  // reference model.
  task automatic runDivision(input string tag, input int a, input int b);
    logic [DATA_SIZE-1:0] expQ;
    logic [FRAC_SIZE-1:0] expF;
    logic                 expOvf, expDz;
    int                   expLat;
    int                   cycles;
    refModel(a, b, expQ, expF, expOvf, expDz, expLat);
    applyStimulus(a, b);
    cycles = 0;
    do begin
      @(posedge clock);
      #1;
      cycles++;
    end while (!valid && cycles < BUDGET);
    checkOutput({tag, ".latency"},  32'(cycles),   32'(expLat));
    checkOutput({tag, ".quotient"}, 32'(quotient), 32'(expQ));
    checkOutput({tag, ".fraction"}, 32'(fraction), 32'(expF));
    checkOutput({tag, ".overflow"}, 32'(overflow), 32'(expOvf));
    checkOutput({tag, ".divzero"},  32'(divZero),  32'(expDz));
    checkOutput({tag, ".ready"},    32'(ready),    32'd1);
    $display("[TB] %s: %0d / %0d -> q=%0h f=%0h ovf=%0b dz=%0b", tag, a, b,
             quotient, fraction, overflow, divZero);
  endtask

  initial begin
    logic [DATA_SIZE-1:0] expQ;
    logic [FRAC_SIZE-1:0] expF;
    logic                 expOvf, expDz;
    int                   expLat;
    int                   validCount;
    int                   firstValid;
    int                   a, b;

    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset.ready",    32'(ready),    32'd1);
    checkOutput("reset.valid",    32'(valid),    32'd0);
    checkOutput("reset.quotient", 32'(quotient), 32'd0);
    checkOutput("reset.fraction", 32'(fraction), 32'd0);
    checkOutput("reset.overflow", 32'(overflow), 32'd0);
    checkOutput("reset.divzero",  32'(divZero),  32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    runDivision("pos",      100,    7);
    runDivision("negnum",  -100,    7);
    runDivision("negden",     7, -100);
    runDivision("minneg1", -512,   -1);
    runDivision("minpos1", -512,    1);
    runDivision("divzero",    5,    0);
    runDivision("negzero",   -5,    0);
    runDivision("zeronum",    0,   -3);
    runDivision("maxmin",   511, -512);

    // Starts pulsed while the divider is busy must be ignored.
    refModel(100, 7, expQ, expF, expOvf, expDz, expLat);
    applyStimulus(100, 7);
    validCount = 0;
    firstValid = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock);
      #1;
      if (valid) begin
        validCount++;
        if (firstValid == 0) firstValid = c;
      end
      if (c == 5) checkOutput("ignore.busy", 32'(ready), 32'd0);
      if (c == 5 || c == 12) begin
        start    = 1'b1;
        dividend = DATA_SIZE'(3);
        divisor  = DATA_SIZE'(1);
      end else begin
        start = 1'b0;
      end
    end
    checkOutput("ignore.count",    32'(validCount), 32'd1);
    checkOutput("ignore.latency",  32'(firstValid), 32'(expLat));
    checkOutput("ignore.quotient", 32'(quotient),   32'(expQ));
    checkOutput("ignore.fraction", 32'(fraction),   32'(expF));

    // A reset in the middle of a division clears the outputs, and the
    // division that was in flight never produces a result.
    applyStimulus(-100, 7);
    repeat (9) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    #1;
    checkOutput("midreset.quotient", 32'(quotient), 32'd0);
    checkOutput("midreset.fraction", 32'(fraction), 32'd0);
    checkOutput("midreset.overflow", 32'(overflow), 32'd0);
    checkOutput("midreset.ready",    32'(ready),    32'd1);
    checkOutput("midreset.valid",    32'(valid),    32'd0);
    @(posedge clock);
    #1;
    checkOutput("midreset.held", 32'(ready), 32'd1);
    #2 reset = 1'b0;
    validCount = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clock);
      #1;
      if (valid) validCount++;
    end
    checkOutput("midreset.novalid", 32'(validCount), 32'd0);

    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, 1023)) - 512;
      b = int'($urandom_range(0, 1023)) - 512;
      if ($urandom_range(0, 9) == 0) b = 0;
      runDivision("rand", a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
